// File: rtl/frog_btn_cond.sv
// Button conditioner for the frog game core: synchronise, debounce and pulse four raw buttons.
// Optional auto-repeat while a button stays held is built only when FROG_BTN_REPEAT_EN is defined.
module frog_btn_cond #(
    parameter int unsigned DB_CYCLES  = 16,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned REP_DELAY  = 2000,
    parameter int unsigned REP_PERIOD = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_go_1,
    input  logic       btn_go_2,
    input  logic       btn_back_1,
    input  logic       btn_back_2,
    output logic       go_1,
    output logic       go_2,
    output logic       back_1,
    output logic       back_2,
    output logic [3:0] held
);

    typedef enum logic [1:0] {StIdle, StDbPress, StHeld, StDbRel} state_e;

    localparam logic [CNT_W-1:0] DbMax  = CNT_W'(DB_CYCLES);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CntOne;
    endfunction

    // Channel order matches held: {back_2, back_1, go_2, go_1}
    logic [3:0] btn_raw;
    assign btn_raw = {btn_back_2, btn_back_1, btn_go_2, btn_go_1};

    logic [3:0]       meta_q, sync_q;
    state_e           state_q [4];
    state_e           state_d [4];
    logic [CNT_W-1:0] cnt_q   [4];
    logic [CNT_W-1:0] cnt_d   [4];
    logic [3:0]       held_q, held_d;
    logic [3:0]       pulse_q, pulse_d;

`ifdef FROG_BTN_REPEAT_EN
    localparam logic [CNT_W-1:0] RepDelay  = CNT_W'(REP_DELAY);
    localparam logic [CNT_W-1:0] RepPeriod = CNT_W'(REP_PERIOD);
    logic [CNT_W-1:0] hold_q [4];
    logic [CNT_W-1:0] hold_d [4];
    logic [3:0]       rep_q, rep_d;
`else
    logic unused_rep_params;
    assign unused_rep_params = ^{REP_DELAY, REP_PERIOD};
`endif

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            held_d[i]  = held_q[i];
            pulse_d[i] = 1'b0;
`ifdef FROG_BTN_REPEAT_EN
            hold_d[i]  = '0;
            rep_d[i]   = 1'b0;
`endif
            unique case (state_q[i])
                StIdle: begin
                    if (sync_q[i]) begin
                        cnt_d[i] = CntOne;
                        if (CntOne >= DbMax) begin
                            state_d[i] = StHeld;
                            pulse_d[i] = 1'b1;
                            held_d[i]  = 1'b1;
                        end else begin
                            state_d[i] = StDbPress;
                        end
                    end
                end
                StDbPress: begin
                    if (!sync_q[i]) begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = sat_inc(cnt_q[i]);
                        if (sat_inc(cnt_q[i]) >= DbMax) begin
                            state_d[i] = StHeld;
                            pulse_d[i] = 1'b1;
                            held_d[i]  = 1'b1;
                        end
                    end
                end
                StHeld: begin
                    held_d[i] = 1'b1;
                    if (!sync_q[i]) begin
                        cnt_d[i] = CntOne;
                        if (CntOne >= DbMax) begin
                            state_d[i] = StIdle;
                            held_d[i]  = 1'b0;
                        end else begin
                            state_d[i] = StDbRel;
                        end
                    end else begin
`ifdef FROG_BTN_REPEAT_EN
                        // hold_q counts cycles since the last pulse of this press
                        hold_d[i] = sat_inc(hold_q[i]);
                        rep_d[i]  = rep_q[i];
                        if ((!rep_q[i] && sat_inc(hold_q[i]) == RepDelay) ||
                            (rep_q[i] && sat_inc(hold_q[i]) == RepPeriod)) begin
                            pulse_d[i] = 1'b1;
                            hold_d[i]  = '0;
                            rep_d[i]   = 1'b1;
                        end
`endif
                    end
                end
                StDbRel: begin
                    if (sync_q[i]) begin
                        state_d[i] = StHeld;
                        cnt_d[i]   = '0;
                        held_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = sat_inc(cnt_q[i]);
                        if (sat_inc(cnt_q[i]) >= DbMax) begin
                            state_d[i] = StIdle;
                            cnt_d[i]   = '0;
                            held_d[i]  = 1'b0;
                        end
                    end
                end
                default: state_d[i] = StIdle;
            endcase
        end
    end

    // Reset parks every channel in StDbRel so a button held through reset never pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= '0;
            sync_q  <= '0;
            held_q  <= '0;
            pulse_q <= '0;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= StDbRel;
                cnt_q[i]   <= '0;
            end
`ifdef FROG_BTN_REPEAT_EN
            rep_q <= '0;
            for (int i = 0; i < 4; i++) hold_q[i] <= '0;
`endif
        end else begin
            meta_q  <= btn_raw;
            sync_q  <= meta_q;
            held_q  <= held_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
`ifdef FROG_BTN_REPEAT_EN
            rep_q <= rep_d;
            for (int i = 0; i < 4; i++) hold_q[i] <= hold_d[i];
`endif
        end
    end

    // Simultaneous go and back from one player cancel each other
    assign go_1   = pulse_q[0] & ~pulse_q[2];
    assign back_1 = pulse_q[2] & ~pulse_q[0];
    assign go_2   = pulse_q[1] & ~pulse_q[3];
    assign back_2 = pulse_q[3] & ~pulse_q[1];
    assign held   = held_q;

endmodule
